// File: rtl/ysyx_lsu_bus_req.sv
// ysyx_lsu_bus_req
//   Load/store request sequencer between the LSU datapath and the bus arbiter's
//   lsu ports. Accepts one op at a time, rejects illegal/misaligned ops with an
//   error response, holds the arbiter valids until completion (or timeout), and
//   sign/zero-extends load data.
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/ready/we/addr/wdata/funct3   upstream request
//   rsp_valid/ready/rdata/err     upstream response
//   lsu_ar*/lsu_r*                arbiter load port
//   lsu_aw*/lsu_w*                arbiter store port
module ysyx_lsu_bus_req #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [2:0]        req_funct3,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] lsu_araddr,
   output logic              lsu_arvalid,
   output logic [7:0]        lsu_rstrb,
   input  logic [DATA_W-1:0] lsu_rdata,
   input  logic              lsu_rvalid,
   output logic [ADDR_W-1:0] lsu_awaddr,
   output logic              lsu_awvalid,
   output logic [DATA_W-1:0] lsu_wdata,
   output logic [7:0]        lsu_wstrb,
   output logic              lsu_wvalid,
   input  logic              lsu_wready
);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StRsp} state_e;

   localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam bit TimeoutEn = (TIMEOUT != 0);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic              req_legal, req_misaligned, timeout_hit;
   logic [7:0]        strb;
   logic [DATA_W-1:0] ext_rdata;

   // Stores have no unsigned variants, so 100/101 are only legal for loads.
   always_comb begin
      unique case (req_funct3)
         3'b000, 3'b001, 3'b010: req_legal = 1'b1;
         3'b100, 3'b101:         req_legal = !req_we;
         default:                req_legal = 1'b0;
      endcase
   end

   assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                           ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

   assign timeout_hit = TimeoutEn && (cnt_q == CntMax);

   always_comb begin
      unique case (funct3_q[1:0])
         2'b01:   strb = 8'h03;
         2'b10:   strb = 8'h0f;
         default: strb = 8'h01;
      endcase
   end

   always_comb begin
      unique case (funct3_q)
         3'b000:  ext_rdata = {{(DATA_W-8){lsu_rdata[7]}}, lsu_rdata[7:0]};
         3'b001:  ext_rdata = {{(DATA_W-16){lsu_rdata[15]}}, lsu_rdata[15:0]};
         3'b100:  ext_rdata = {{(DATA_W-8){1'b0}}, lsu_rdata[7:0]};
         3'b101:  ext_rdata = {{(DATA_W-16){1'b0}}, lsu_rdata[15:0]};
         default: ext_rdata = lsu_rdata;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      funct3_d = funct3_q;
      we_d     = we_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      cnt_d    = cnt_q + CntW'(1);
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (req_valid) begin
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               funct3_d = req_funct3;
               we_d     = req_we;
               rdata_d  = '0;
               err_d    = 1'b0;
               if (!req_legal || req_misaligned) begin
                  err_d   = 1'b1;
                  state_d = StRsp;
               end else if (req_we) begin
                  state_d = StWr;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StRd: begin
            // A completion on the expiring cycle takes priority over the timeout.
            if (lsu_rvalid) begin
               rdata_d = ext_rdata;
               err_d   = 1'b0;
               state_d = StRsp;
            end else if (timeout_hit) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = StRsp;
            end
         end
         StWr: begin
            if (lsu_wready) begin
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = StRsp;
            end else if (timeout_hit) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = StRsp;
            end
         end
         StRsp: begin
            cnt_d = '0;
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         we_q     <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         we_q     <= we_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   // Every valid and payload decodes from the registered state only.
   assign req_ready   = (state_q == StIdle);
   assign rsp_valid   = (state_q == StRsp);
   assign rsp_rdata   = (state_q == StRsp) ? rdata_q : '0;
   assign rsp_err     = (state_q == StRsp) && err_q;

   assign lsu_arvalid = (state_q == StRd);
   assign lsu_araddr  = (state_q == StRd) ? addr_q : '0;
   assign lsu_rstrb   = (state_q == StRd) ? strb : 8'h00;

   assign lsu_awvalid = (state_q == StWr);
   assign lsu_wvalid  = (state_q == StWr);
   assign lsu_awaddr  = (state_q == StWr) ? addr_q : '0;
   assign lsu_wdata   = (state_q == StWr) ? wdata_q : '0;
   assign lsu_wstrb   = (state_q == StWr) ? strb : 8'h00;

endmodule
